ones_count_scheduler: RTL and testbench

- Shares one serial ones-counting engine among NUM_REQ requesters using round-robin arbitration.
- Each accepted request has its data word scanned one bit per clock, LSB first.
- The engine returns the popcount of the word, tagged with the winning requester's ID.
- Sits between several client blocks and a single bit-serial counter datapath, so the counter does not have to be replicated per client.

---
 rtl/ones_count_scheduler_pkg.sv | 34 +++
 rtl/ones_count_engine.sv | 56 +++++
 rtl/ones_count_scheduler.sv | 135 +++++++++++++
 tb/tb_ones_count_scheduler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ones_count_scheduler_pkg.sv
// Shared definitions for the round-robin popcount scheduler.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
package ones_count_scheduler_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Bits needed to index positions 0..w-1 (never zero wide).
    function automatic int idx_width(input int w);
        return (w <= 1) ? 1 : clog2_f(w);
    endfunction

    // Parameter sanity: result must hold data_width, id must hold NUM_REQ-1.
    function automatic bit widths_ok(input int num_req, input int data_width,
                                     input int count_width, input int id_width);
        return (num_req >= 2) && (num_req <= 8) &&
               (count_width >= clog2_f(data_width + 1)) &&
               (id_width >= clog2_f(num_req));
    endfunction

endpackage

// File: rtl/ones_count_engine.sv
// Bit-serial popcount datapath: scans a loaded word LSB first, one bit per clock.
// Latency: data_width clocks from start; done/result are combinational on the last scan cycle.
// Backpressure: none; start is only legal while idle, the caller owns sequencing.
//
// Ports: clk, reset (async active-high), start + load_data (capture a word),
//        done (high during the final scan cycle), result (popcount valid with done).
module ones_count_engine
    import ones_count_scheduler_pkg::*;
#(
    parameter int data_width  = 8,
    parameter int count_width = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [data_width-1:0]  load_data,
    output logic                   done,
    output logic [count_width-1:0] result
);

    localparam int IW = idx_width(data_width);

    logic [data_width-1:0]  sreg;
    logic [count_width-1:0] cnt;
    logic [count_width-1:0] cnt_next;
    logic [IW-1:0]          idx;
    logic                   active;

    // Sum includes the bit being consumed this cycle so the last bit is
    // folded into the result without an extra clock.
    assign cnt_next = cnt + count_width'(sreg[0]);
    assign done     = active && (idx == IW'(data_width - 1));
    assign result   = cnt_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg   <= '0;
            cnt    <= '0;
            idx    <= '0;
            active <= 1'b0;
        end else if (start) begin
            sreg   <= load_data;
            cnt    <= '0;
            idx    <= '0;
            active <= 1'b1;
        end else if (active) begin
            sreg <= sreg >> 1;
            cnt  <= cnt_next;
            idx  <= idx + IW'(1);
            if (done) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ones_count_scheduler.sv
// Round-robin front end sharing one serial popcount engine among NUM_REQ requesters.
// Latency: gnt at E0, done data_width clocks later; one job per data_width+1 clocks.
// Backpressure: requesters hold req/data until their gnt pulse; requests seen while counting wait for the next IDLE edge.
//
// Ports: clk, reset (async active-high), req[NUM_REQ], data_bus (word i at
//        [i*data_width +: data_width]), gnt (one-hot pulse), busy, done (pulse),
//        done_id / bit_count (held until the next done).
module ones_count_scheduler
    import ones_count_scheduler_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int data_width  = 8,
    parameter int count_width = 4,
    parameter int id_width    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*data_width-1:0] data_bus,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          busy,
    output logic                          done,
    output logic [id_width-1:0]           done_id,
    output logic [count_width-1:0]        bit_count
);

    if (!widths_ok(NUM_REQ, data_width, count_width, id_width)) begin : g_bad_params
        $error("ones_count_scheduler: parameter widths are inconsistent");
    end

    state_t                 state;
    state_t                 state_next;
    logic [id_width-1:0]    last;
    logic [id_width-1:0]    cur_id;
    logic [id_width-1:0]    winner;
    logic [NUM_REQ-1:0]     win_onehot;
    logic [data_width-1:0]  win_data;
    logic                   found;
    logic                   start;
    logic                   eng_done;
    logic [count_width-1:0] eng_result;

    // Round-robin pick: first requester strictly above the last winner,
    // otherwise wrap and take the lowest requester.
    always_comb begin
        winner     = '0;
        win_onehot = '0;
        win_data   = '0;
        found      = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i > int'(last))) begin
                winner        = id_width'(i);
                win_onehot    = '0;
                win_onehot[i] = 1'b1;
                win_data      = data_bus[i*data_width +: data_width];
                found         = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                winner        = id_width'(i);
                win_onehot    = '0;
                win_onehot[i] = 1'b1;
                win_data      = data_bus[i*data_width +: data_width];
                found         = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    start      = 1'b1;
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (eng_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last      <= id_width'(NUM_REQ - 1);
            cur_id    <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            done_id   <= '0;
            bit_count <= '0;
        end else begin
            gnt  <= start ? win_onehot : '0;
            done <= eng_done;
            if (start) begin
                last   <= winner;
                cur_id <= winner;
                busy   <= 1'b1;
            end else if (eng_done) begin
                busy <= 1'b0;
            end
            if (eng_done) begin
                bit_count <= eng_result;
                done_id   <= cur_id;
            end
        end
    end

    ones_count_engine #(
        .data_width  (data_width),
        .count_width (count_width)
    ) u_engine (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .load_data (win_data),
        .done      (eng_done),
        .result    (eng_result)
    );

endmodule

// File: tb/tb_ones_count_scheduler.sv
module tb_ones_count_scheduler;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [N*W-1:0] data_bus;
    logic [N-1:0]  gnt;
    logic          busy;
    logic          done;
    logic [IW-1:0] done_id;
    logic [CW-1:0] bit_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ones_count_scheduler #(
        .NUM_REQ     (N),
        .data_width  (W),
        .count_width (CW),
        .id_width    (IW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .data_bus  (data_bus),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .bit_count (bit_count)
    );

    typedef struct {
        int        id;
        logic [7:0] data;
        logic [3:0] exp_cnt;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Single uncontended job starting at a negedge with the DUT idle.
    task automatic run_job(input int id, input logic [7:0] d, input logic [3:0] exp_cnt);
        logic [N-1:0] oh;
        oh = '0;
        oh[id] = 1'b1;
        data_bus[id*W +: W] = d;
        req = oh;
        @(posedge clk);
        @(negedge clk);
        check("job_gnt", gnt, oh);
        check("job_busy_e0", busy, 1);
        check("job_done_low_e0", done, 0);
        req = '0;
        for (int k = 1; k < W; k++) begin
            @(negedge clk);
            check("job_gnt_low", gnt, 0);
            check("job_busy", busy, 1);
            check("job_done_low", done, 0);
        end
        @(negedge clk);
        check("job_done", done, 1);
        check("job_busy_end", busy, 0);
        check("job_bit_count", bit_count, exp_cnt);
        check("job_done_id", done_id, id);
        @(negedge clk);
        check("job_done_pulse", done, 0);
        check("job_bit_count_held", bit_count, exp_cnt);
    endtask

    task automatic wait_idle();
        int ok;
        ok = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (!busy && !done && gnt == '0) begin
                ok = 1;
                break;
            end
        end
        check("idle_reached", ok, 1);
    endtask

    initial begin
        logic [3:0] rr_cnt[N];
        int         exp_order[5];
        int         grants;
        int         last_g;
        int         prev_id;
        logic [N-1:0] pend;
        logic [N-1:0] oh;
        int         saw_done;

        vecs[0] = '{0, 8'hB5, 4'd5};
        vecs[1] = '{2, 8'h00, 4'd0};
        vecs[2] = '{3, 8'hFF, 4'd8};
        vecs[3] = '{1, 8'h01, 4'd1};
        vecs[4] = '{2, 8'h80, 4'd1};
        vecs[5] = '{1, 8'hAA, 4'd4};
        vecs[6] = '{3, 8'h3C, 4'd4};

        reset    = 1'b1;
        req      = '0;
        data_bus = '0;
        #12;
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_done_id", done_id, 0);
        check("rst_bit_count", bit_count, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            run_job(vecs[v].id, vecs[v].data, vecs[v].exp_cnt);
        end

        // Round-robin under continuous requests: restart pointer with a reset.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        data_bus = {8'h00, 8'hFE, 8'h03, 8'h0F};
        rr_cnt   = '{4'd4, 4'd2, 4'd7, 4'd0};
        exp_order = '{0, 1, 2, 3, 0};
        req    = 4'b1111;
        grants = 0;
        last_g = -1;
        prev_id = -1;
        pend   = '0;
        for (int c = 0; c < 80 && grants < 5; c++) begin
            @(negedge clk);
            if (done) begin
                check("rr_done_id", done_id, prev_id);
                check("rr_bit_count", bit_count, rr_cnt[prev_id]);
                check("rr_no_gnt_with_done", gnt, 0);
            end
            if (gnt != '0) begin
                oh = '0;
                oh[exp_order[grants]] = 1'b1;
                check("rr_gnt_order", gnt, oh);
                if (last_g >= 0) begin
                    check("rr_gnt_spacing", c - last_g, 9);
                end
                last_g  = c;
                prev_id = exp_order[grants];
                grants++;
                pend = gnt;
                req  = req & ~gnt;
            end else if (pend != '0) begin
                req  = req | pend;
                pend = '0;
            end
        end
        check("rr_grant_count", grants, 5);
        req = '0;
        wait_idle();

        // Request arriving mid-count waits for the IDLE edge after done.
        data_bus[0*W +: W] = 8'h0F;
        req = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        check("late_gnt0", gnt, 4'b0001);
        req = '0;
        @(negedge clk);
        req = 4'b0010;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) break;
            check("late_no_early_gnt", gnt, 0);
        end
        check("late_done_seen", done, 1);
        check("late_done_id", done_id, 0);
        check("late_gnt_with_done", gnt, 0);
        @(negedge clk);
        check("late_immediate_gnt", gnt, 4'b0010);
        check("late_done_fell", done, 0);
        req = '0;
        wait_idle();
        check("late_job1_count", bit_count, 2);
        check("late_job1_id", done_id, 1);

        // Asynchronous reset in the middle of a job from requester 2.
        data_bus[2*W +: W] = 8'h77;
        req = 4'b0100;
        @(posedge clk);
        @(negedge clk);
        check("abort_gnt", gnt, 4'b0100);
        req = '0;
        for (int k = 0; k < 3; k++) @(negedge clk);
        check("abort_busy_before", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("abort_gnt_zero", gnt, 0);
        check("abort_busy_zero", busy, 0);
        check("abort_done_zero", done, 0);
        check("abort_done_id_zero", done_id, 0);
        check("abort_bit_count_zero", bit_count, 0);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        check("abort_no_done", saw_done, 0);
        req = 4'b1110;
        @(posedge clk);
        @(negedge clk);
        check("abort_priority_restart", gnt, 4'b0010);
        req = '0;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
